// File: rtl/gumnut_int_ctrl.sv
// ============================================================================
// Module   : gumnut_int_ctrl
// Brief    : Port-mapped 8-source interrupt controller for the Gumnut core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gumnut_int_ctrl #(
    parameter int          N_SRC     = 8,
    parameter logic [7:0]  BASE_ADDR = 8'hF0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_i,
    input  logic             port_cyc_i,
    input  logic             port_stb_i,
    input  logic             port_we_i,
    input  logic [7:0]       port_adr_i,
    input  logic [7:0]       port_dat_i,
    output logic [7:0]       port_dat_o,
    output logic             port_ack_o,
    output logic             int_req_o,
    input  logic             int_ack_i
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;

    localparam logic [2:0] C_OFF_PEND = 3'd0;
    localparam logic [2:0] C_OFF_MASK = 3'd1;
    localparam logic [2:0] C_OFF_VECT = 3'd2;
    localparam logic [2:0] C_OFF_EDGE = 3'd3;
    localparam logic [2:0] C_OFF_CTRL = 3'd4;

    logic [1:0]       r_state;
    logic [N_SRC-1:0] r_pend;
    logic [N_SRC-1:0] r_mask;
    logic [N_SRC-1:0] r_edge;
    logic [N_SRC-1:0] r_src_q;
    logic             r_gie;
    logic             r_vect_valid;
    logic [2:0]       r_vect_id;
    logic             r_ack;
    logic [7:0]       r_dat;
    logic             r_int_req;

    logic [7:0]       w_off;
    logic             w_in_range;
    logic             w_acc;
    logic             w_wr;
    logic             w_rd;
    logic             w_wr_pend;
    logic             w_wr_vect;
    logic             w_eoi;
    logic             w_take_ack;
    logic [N_SRC-1:0] w_cand;
    logic [N_SRC-1:0] w_cand_onehot;
    logic [2:0]       w_cand_id;
    logic             w_cand_any;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_pend_nxt;
    logic [1:0]       w_state_nxt;
    logic [7:0]       w_pend8;
    logic [7:0]       w_mask8;
    logic [7:0]       w_edge8;
    logic [7:0]       w_rdata;

    // Offset wraps modulo 256, so only BASE_ADDR..BASE_ADDR+4 decode.
    assign w_off      = port_adr_i - BASE_ADDR;
    assign w_in_range = (w_off <= 8'd4);
    assign w_acc      = port_cyc_i & port_stb_i & w_in_range & ~r_ack;
    assign w_wr       = w_acc & port_we_i;
    assign w_rd       = w_acc & ~port_we_i;
    assign w_wr_pend  = w_wr & (w_off[2:0] == C_OFF_PEND);
    assign w_wr_vect  = w_wr & (w_off[2:0] == C_OFF_VECT);
    assign w_eoi      = w_wr_vect & (r_state == S_SERVICE);
    assign w_take_ack = int_ack_i & (r_state == S_REQ);

    assign w_cand     = r_pend & r_mask;
    assign w_cand_any = |w_cand;

    // Scan from the top so the lowest-numbered candidate is the last to win.
    always_comb begin
        w_cand_id     = 3'd0;
        w_cand_onehot = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_cand_id        = 3'(i);
                w_cand_onehot    = '0;
                w_cand_onehot[i] = 1'b1;
            end
        end
    end

    // Edge bits: a new rising edge beats any clear; level bits track the input.
    assign w_clr      = (w_wr_pend  ? port_dat_i[N_SRC-1:0] : '0)
                      | (w_take_ack ? w_cand_onehot         : '0);
    assign w_pend_nxt = (r_edge & ((src_i & ~r_src_q) | (r_pend & ~w_clr)))
                      | (~r_edge & src_i);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (r_gie && w_cand_any) w_state_nxt = S_REQ;
            S_REQ:     if (int_ack_i)           w_state_nxt = S_SERVICE;
            S_SERVICE: if (w_eoi)               w_state_nxt = S_IDLE;
            default:                            w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pend8              = '0;
        w_mask8              = '0;
        w_edge8              = '0;
        w_pend8[N_SRC-1:0]   = r_pend;
        w_mask8[N_SRC-1:0]   = r_mask;
        w_edge8[N_SRC-1:0]   = r_edge;
        case (w_off[2:0])
            C_OFF_PEND: w_rdata = w_pend8;
            C_OFF_MASK: w_rdata = w_mask8;
            C_OFF_VECT: w_rdata = {r_vect_valid, 4'b0000, r_vect_id};
            C_OFF_EDGE: w_rdata = w_edge8;
            C_OFF_CTRL: w_rdata = {7'b0000000, r_gie};
            default:    w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pend       <= '0;
            r_mask       <= '0;
            r_edge       <= '0;
            r_src_q      <= '0;
            r_gie        <= 1'b0;
            r_vect_valid <= 1'b0;
            r_vect_id    <= 3'd0;
            r_ack        <= 1'b0;
            r_dat        <= 8'h00;
            r_int_req    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_int_req <= (w_state_nxt == S_REQ);
            r_pend    <= w_pend_nxt;
            r_src_q   <= src_i;
            r_ack     <= w_acc;
            r_dat     <= w_rd ? w_rdata : 8'h00;

            if (w_wr && (w_off[2:0] == C_OFF_MASK)) r_mask <= port_dat_i[N_SRC-1:0];
            if (w_wr && (w_off[2:0] == C_OFF_EDGE)) r_edge <= port_dat_i[N_SRC-1:0];
            if (w_wr && (w_off[2:0] == C_OFF_CTRL)) r_gie  <= port_dat_i[0];

            // A spurious acknowledge leaves VECT reading 0x00.
            if (w_take_ack) begin
                r_vect_valid <= w_cand_any;
                r_vect_id    <= w_cand_any ? w_cand_id : 3'd0;
            end else if (w_eoi) begin
                r_vect_valid <= 1'b0;
            end
        end
    end

    assign port_ack_o = r_ack;
    assign port_dat_o = r_dat;
    assign int_req_o  = r_int_req;

endmodule

`default_nettype wire

// File: tb/tb_gumnut_int_ctrl.sv
// ============================================================================
// Module   : tb_gumnut_int_ctrl
// Brief    : Directed plus random bench for gumnut_int_ctrl with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gumnut_int_ctrl;

    localparam int         NS   = 8;
    localparam logic [7:0] BASE = 8'hF0;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [7:0] src  = 8'h00;
    logic       cyc  = 1'b0;
    logic       stb  = 1'b0;
    logic       we   = 1'b0;
    logic [7:0] adr  = 8'h00;
    logic [7:0] wdat = 8'h00;
    logic       iack = 1'b0;
    logic [7:0] rdat;
    logic       pack;
    logic       ireq;
    logic       mon_en = 1'b0;
    logic [7:0] q;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    gumnut_int_ctrl #(.N_SRC(NS), .BASE_ADDR(BASE)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .src_i      (src),
        .port_cyc_i (cyc),
        .port_stb_i (stb),
        .port_we_i  (we),
        .port_adr_i (adr),
        .port_dat_i (wdat),
        .port_dat_o (rdat),
        .port_ack_o (pack),
        .int_req_o  (ireq),
        .int_ack_i  (iack)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: registers as bytes, phase 0=idle 1=requesting 2=in service.
    bit [7:0] m_pend, m_mask, m_edge, m_vect, m_srcq, m_dat;
    bit       m_gie, m_ack, m_req;
    int       m_phase;

    function automatic bit [7:0] m_reg(input int off);
        case (off)
            0:       return m_pend;
            1:       return m_mask;
            2:       return m_vect;
            3:       return m_edge;
            4:       return {7'd0, m_gie};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_step();
        int       off, pick, nphase;
        bit       acc, wr;
        bit [7:0] cand, clr, np;
        off = int'(adr) - int'(BASE);
        acc = cyc && stb && off >= 0 && off <= 4 && !m_ack;
        wr  = acc && we;
        if (rst) begin
            m_pend = 0; m_mask = 0; m_edge = 0; m_vect = 0; m_srcq = 0;
            m_gie = 0; m_ack = 0; m_dat = 0; m_phase = 0;
        end else begin
            cand = m_pend & m_mask;
            pick = -1;
            for (int i = 0; i < NS; i++) if (cand[i] && pick < 0) pick = i;
            m_dat  = (acc && !we) ? m_reg(off) : 8'h00;
            m_ack  = acc;
            clr    = 0;
            nphase = m_phase;
            if (m_phase == 0 && m_gie && cand != 0) nphase = 1;
            else if (m_phase == 1 && iack) begin
                nphase = 2;
                if (pick >= 0) begin
                    m_vect    = 8'h80 | 8'(pick);
                    clr[pick] = 1'b1;
                end else m_vect = 8'h00;
            end else if (m_phase == 2 && wr && off == 2) begin
                nphase    = 0;
                m_vect[7] = 1'b0;
            end
            if (wr && off == 0) clr |= wdat;
            for (int i = 0; i < NS; i++) begin
                if (!m_edge[i])               np[i] = src[i];
                else if (src[i] && !m_srcq[i]) np[i] = 1'b1;
                else if (clr[i])              np[i] = 1'b0;
                else                          np[i] = m_pend[i];
            end
            m_pend  = np;
            m_srcq  = src;
            m_phase = nphase;
            if (wr && off == 1) m_mask = wdat;
            if (wr && off == 3) m_edge = wdat;
            if (wr && off == 4) m_gie  = wdat[0];
        end
        m_req = (m_phase == 1);
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (mon_en) begin
            check("int_req", {7'd0, ireq}, {7'd0, m_req});
            check("port_ack", {7'd0, pack}, {7'd0, m_ack});
            check("port_dat", rdat, m_dat);
        end
    end

    task automatic bus_xfer(input bit w, input int off, input logic [7:0] d, output logic [7:0] r);
        int k;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = BASE + 8'(off); wdat = d;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!pack && k < 4);
        if (!pack) check("bus_timeout", 8'h00, 8'h01);
        r = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input int off, input logic [7:0] d);
        logic [7:0] dummy;
        bus_xfer(1'b1, off, d, dummy);
    endtask

    task automatic rd(input string tag, input int off, input logic [7:0] exp);
        logic [7:0] r;
        bus_xfer(1'b0, off, 8'h00, r);
        check(tag, r, exp);
    endtask

    task automatic wait_req(input string tag);
        for (int k = 0; k < 10 && !ireq; k++) @(negedge clk);
        check(tag, {7'd0, ireq}, 8'h01);
    endtask

    task automatic pulse_ack();
        @(negedge clk); iack = 1'b1;
        @(negedge clk); iack = 1'b0;
        check("req_drop_on_ack", {7'd0, ireq}, 8'h00);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        rst    = 1'b0;

        // Reset values and out-of-range decode.
        for (int i = 0; i < 5; i++) rd("reset_reg", i, 8'h00);
        check("reset_req", {7'd0, ireq}, 8'h00);
        @(negedge clk); cyc = 1'b1; stb = 1'b1; adr = BASE + 8'd5;
        repeat (3) begin
            @(negedge clk);
            check("oor_no_ack", {7'd0, pack}, 8'h00);
        end
        cyc = 1'b0; stb = 1'b0;

        // Single edge source, two-cycle latency.
        wr(1, 8'h01); wr(3, 8'h01); wr(4, 8'h01);
        @(negedge clk); src = 8'h01;
        @(negedge clk); src = 8'h00;
        check("lat_edge_k", {7'd0, ireq}, 8'h00);
        @(negedge clk);
        check("lat_edge_k1", {7'd0, ireq}, 8'h01);
        pulse_ack();
        rd("vect_src0", 2, 8'h80);
        rd("pend_after_ack", 0, 8'h00);
        wr(2, 8'h00);
        rd("vect_after_eoi", 2, 8'h00);

        // Two simultaneous edges, lowest index first.
        wr(1, 8'hFF); wr(3, 8'hFF);
        @(negedge clk); src = 8'h24;
        @(negedge clk); src = 8'h00;
        wait_req("req_pair");
        pulse_ack();
        rd("vect_src2", 2, 8'h82);
        rd("pend_src5", 0, 8'h20);
        wr(2, 8'h00);
        wait_req("req_reassert");
        pulse_ack();
        rd("vect_src5", 2, 8'h85);
        wr(2, 8'h00);

        // Level source 3.
        wr(3, 8'hF7);
        @(negedge clk); src = 8'h08;
        wait_req("req_level");
        pulse_ack();
        rd("vect_src3", 2, 8'h83);
        wr(0, 8'h08);
        rd("pend_level_w1c", 0, 8'h08);
        wr(2, 8'h00);
        wait_req("req_level_again");
        @(negedge clk); src = 8'h00;
        repeat (2) @(negedge clk);
        pulse_ack();
        rd("vect_level_gone", 2, 8'h00);
        wr(2, 8'h00);
        repeat (4) @(negedge clk);
        check("idle_after_level", {7'd0, ireq}, 8'h00);

        // Sticky request with candidate removed: spurious ack.
        wr(3, 8'hFF); wr(1, 8'h01);
        @(negedge clk); src = 8'h01;
        @(negedge clk); src = 8'h00;
        wait_req("req_before_spur");
        wr(1, 8'h00);
        check("req_sticky", {7'd0, ireq}, 8'h01);
        pulse_ack();
        rd("vect_spurious", 2, 8'h00);
        rd("pend_kept_spur", 0, 8'h01);
        wr(2, 8'h00);
        repeat (3) @(negedge clk);
        check("idle_after_spur", {7'd0, ireq}, 8'h00);
        wr(0, 8'h01);
        rd("pend_w1c", 0, 8'h00);

        // Reset aborting an accepted write.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 8'd1; wdat = 8'hFF; rst = 1'b1;
        @(negedge clk);
        check("rst_no_ack", {7'd0, pack}, 8'h00);
        check("rst_req", {7'd0, ireq}, 8'h00);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
        rd("rst_mask", 1, 8'h00);

        // Random traffic checked cycle by cycle against the model.
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            src  = src ^ 8'($urandom & $urandom & $urandom);
            iack = ($urandom_range(0, 3) == 0);
            cyc  = ($urandom_range(0, 2) != 0);
            stb  = ($urandom_range(0, 3) != 0);
            we   = $urandom_range(0, 1) == 1;
            adr  = ($urandom_range(0, 15) == 0) ? 8'($urandom) : BASE + 8'($urandom_range(0, 6));
            wdat = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'hFF;
            rst  = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; iack = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
